// File: rtl/beat_generator.sv
`default_nettype none
// beat_generator: sequencer timebase; beat every (tempo+1) clocks, wrapping step, downbeat pulse.
// Rev 1.0
module beat_generator #(
  parameter int TEMPO_W = 22,
  parameter int STEPS   = 8,
  parameter int STEP_W  = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic               restart,
  input  logic [TEMPO_W-1:0] tempo,
  output logic               beat_pulse,
  output logic [STEP_W-1:0]  step,
  output logic               measure_pulse,
  output logic               running
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(STEPS - 1);

  state_t             state, state_next;
  logic [TEMPO_W-1:0] cnt, cnt_next;
  logic [TEMPO_W-1:0] tempo_lat, tempo_lat_next;
  logic [STEP_W-1:0]  step_reg, step_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      tempo_lat <= '0;
      step_reg  <= '0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      tempo_lat <= tempo_lat_next;
      step_reg  <= step_next;
    end
  end

  // Every edge that starts a beat also samples tempo, so a mid-beat change
  // only affects the interval that follows the next beat.
  always_comb begin
    state_next     = state;
    cnt_next       = cnt;
    tempo_lat_next = tempo_lat;
    step_next      = step_reg;
    case (state)
      IDLE: begin
        cnt_next  = '0;
        step_next = '0;
        if (run) begin
          state_next     = RUN;
          tempo_lat_next = tempo;
        end
      end
      RUN: begin
        if (!run) begin
          state_next = IDLE;
          cnt_next   = '0;
          step_next  = '0;
        end else if (restart) begin
          cnt_next       = '0;
          step_next      = '0;
          tempo_lat_next = tempo;
        end else if (cnt == tempo_lat) begin
          cnt_next       = '0;
          step_next      = (step_reg == LAST_STEP) ? '0 : step_reg + 1'b1;
          tempo_lat_next = tempo;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
        step_next  = '0;
      end
    endcase
  end

  assign running       = (state == RUN);
  assign beat_pulse    = running && (cnt == '0);
  assign step          = step_reg;
  assign measure_pulse = beat_pulse && (step_reg == '0);

endmodule
`default_nettype wire
